// File: rtl/io_device_fifo.sv
// Circular word buffer for a DMA-serviced I/O device: filled by a local producer,
// DMA write bursts or CPU indexed writes, drained by DMA read bursts.
module io_device_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int IDX_W      = 9,
    parameter int BASE       = 192,
    parameter int IRQ_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IDX_W-1:0]         index,
    input  logic                     io_write,
    input  logic                     ack,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_oe,
    output logic                     gpio,
    input  logic                     ext_valid,
    input  logic [DATA_W-1:0]        ext_data,
    output logic                     ext_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = IDX_W - 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic              gpio_q, gpio_d;
    logic              underflow_q, underflow_d;
    logic              overflow_q, overflow_d;
    logic              cs_err_q, cs_err_d;

    logic              cs, cpu_rd, cpu_wr, is_slot, is_status, status_clr;
    logic              full, empty, pop, push, ext_push, dma_push, dma_rd, dma_wr;
    logic [OW-1:0]     off;
    logic [AW-1:0]     slot_ptr;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] status_word;

    always_comb begin
        cs        = index[IDX_W-1];
        off       = index[OW-1:0] - OW'(BASE);
        is_slot   = off < OW'(DEPTH);
        is_status = off == OW'(DEPTH);
        slot_ptr  = rd_ptr_q + off[AW-1:0];

        dma_rd    = ack && !io_write;
        dma_wr    = ack && io_write;
        full      = count_q == CW'(DEPTH);
        empty     = count_q == '0;

        // ext_ready looks only at registered count, so a same-cycle pop never opens a slot when full
        ext_ready = !full && !dma_wr;
        ext_push  = ext_valid && ext_ready;
        dma_push  = dma_wr && !full;
        pop       = dma_rd && !empty;
        push      = ext_push || dma_push;
        push_data = dma_wr ? data_in : ext_data;

        // CPU accesses are only honoured when no DMA burst owns the cycle
        cpu_rd     = cs && !ack && !io_write;
        cpu_wr     = cs && !ack && io_write;
        status_clr = cpu_wr && is_status;

        status_word            = '0;
        status_word[CW-1:0]    = count_q;
        status_word[CW]        = gpio_q;
        status_word[CW+1]      = underflow_q;
        status_word[CW+2]      = overflow_q;
        status_word[CW+3]      = cs_err_q;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        data_out_d = data_out_q;
        data_oe_d  = 1'b0;

        if (pop) begin
            data_out_d = mem_q[rd_ptr_q];
            data_oe_d  = 1'b1;
        end else if (cpu_rd) begin
            data_oe_d = 1'b1;
            if (is_slot) begin
                data_out_d = mem_q[slot_ptr];
            end else if (is_status) begin
                data_out_d = status_word;
            end else begin
                data_out_d = '0;
            end
        end

        // Flag events override a simultaneous W1C clear
        underflow_d = (underflow_q && !(status_clr && data_in[CW+1])) || (dma_rd && empty);
        overflow_d  = (overflow_q  && !(status_clr && data_in[CW+2])) || (dma_wr && full);
        cs_err_d    = (cs_err_q    && !(status_clr && data_in[CW+3])) || (ack && cs);

        if (count_d == '0) begin
            gpio_d = 1'b0;
        end else if (count_d >= CW'(IRQ_THRESH)) begin
            gpio_d = 1'b1;
        end else begin
            gpio_d = gpio_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            gpio_q      <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            cs_err_q    <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            gpio_q      <= gpio_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            cs_err_q    <= cs_err_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
        if (cpu_wr && is_slot) begin
            mem_q[slot_ptr] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign gpio     = gpio_q;
    assign count    = count_q;

endmodule

// File: doc/io_device_fifo.md
Name: io_device_fifo

Overview:
- Parametrised successor to the single-channel DMA I/O peripheral model.
- Holds a circular word buffer that three sources can fill:
  - a local producer port, replacing file-driven stimulus;
  - DMA acknowledged bursts;
  - CPU indexed writes.
- Raises a GPIO service request to the DMA controller when occupancy reaches a threshold.
- Drains one word per clock during an acknowledged DMA read burst.
- Exposes a CPU-visible status register with sticky error flags.

Parameters:
DATA_W, 32, data word width
DEPTH, 32, buffer depth in words; power of two, minimum 4
IDX_W, 9, width of index bus; MSB is chip select
BASE, 192, offset in index[IDX_W-2:0] of slot 0
IRQ_THRESH, 1, occupancy (1..DEPTH) at which gpio asserts

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
index  input  IDX_W  CPU address; index[IDX_W-1]=CS, low bits=offset
io_write  input  1  1 = write into device, 0 = read from device
ack  input  1  DMA acknowledge; burst transfer enable
data_in  input  DATA_W  write data (CPU or DMA)
data_out  output  DATA_W  registered read data
data_oe  output  1  data_out valid / drive enable for shared bus
gpio  output  1  service request to DMA controller
ext_valid  input  1  local producer word valid
ext_data  input  DATA_W  local producer word
ext_ready  output  1  buffer accepts ext word this cycle
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - data_out, data_oe, gpio, count, rd_ptr, wr_ptr and all sticky flags = 0.
  - Buffer contents are not reset.
  - Reset mid-burst aborts the burst immediately; count returns to 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is exact: 0..DEPTH; full when count==DEPTH.
- Priority per cycle: ack > CS access. CS access (index MSB=1) while ack=1 is ignored and sets sticky cs_err.
- DMA read (ack=1, io_write=0):
  - If count>0: data_out <= buf[rd_ptr], rd_ptr++, count-- at this edge; data_oe=1 in the following cycle.
  - Throughput is one word per cycle while ack is held.
  - If count==0: no pointer change, data_oe=0, sticky underflow set.
- DMA write (ack=1, io_write=1):
  - If count<DEPTH: buf[wr_ptr] <= data_in, wr_ptr++.
  - Else: word dropped, sticky overflow set.
- Local producer:
  - ext_ready = (count<DEPTH) && !(ack && io_write), combinational.
  - Push when ext_valid && ext_ready.
- Simultaneous push and pop (ext push or DMA write, together with DMA read): both occur and count is unchanged.
  - When full, a simultaneous pop does not enable a push; ext_ready uses registered count.
- CPU access (CS=1, ack=0), with off = index[IDX_W-2:0] - BASE:
  - 0 <= off < DEPTH:
    - Write: buf[(rd_ptr+off) mod DEPTH] <= data_in; count unchanged.
    - Read: data_out <= that slot; data_oe=1 next cycle.
  - off == DEPTH (status register):
    - Read returns {zeros, cs_err, overflow, underflow, gpio, count} with count in the LSBs.
    - Write: data_in bits set to 1 at flag positions clear those flags (W1C). A flag event in the same cycle wins over the clear.
  - Any other off: read returns 0 with data_oe=1; write is ignored.
- data_oe is 0 in every cycle not following an accepted read.
- gpio is registered with hysteresis:
  - Set when next count >= IRQ_THRESH.
  - Cleared only when next count == 0 (end of burst drain).
  - Otherwise holds.

Test Plan:
- Reset then idle 5 cycles -> data_out=0, data_oe=0, gpio=0, count=0, ext_ready=1.
- Push 3 ext words 0xA,0xB,0xC; IRQ_THRESH=1 -> gpio=1 one cycle after the first push. Then ack=1, io_write=0 for 4 cycles -> data_out 0xA,0xB,0xC on consecutive cycles with data_oe=1; 4th pop sets underflow; gpio=0 after drain.
- DMA write 33 words with DEPTH=32 -> count=32, ext_ready=0, 33rd word dropped, overflow=1. Status read (index=256+192+32) -> overflow bit=1. W1C write clears it.
- Fill 30, pop 29, push 5 -> pointers wrap. Pops return words in push order; count tracks 0..32 exactly.
- ext push and DMA read in the same cycle at count=5 -> count stays 5; popped word is the oldest.
- CPU read index=256+192+2 with count=4 -> data_out = third-oldest word next cycle. Same access with ack=1 -> ignored, cs_err=1.
